// File: rtl/sdm_interpolator.sv
// Linear-interpolating upsampler feeding the sigma-delta modulator: one PCM sample in
// per 2**RATIO_LOG2 clocks, one interpolated sample out per clock.
module sdm_interpolator #(
    parameter int DW         = 16,
    parameter int RATIO_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_data,
    output logic                 valid_out,
    output logic signed [DW-1:0] dout,
    output logic                 underrun
);

    localparam int AW = DW + RATIO_LOG2;
    localparam int PW = RATIO_LOG2 + 1;
    localparam logic [PW-1:0] R = PW'(1 << RATIO_LOG2);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t               state;
    logic [PW-1:0]        phase;
    logic signed [DW-1:0] base;
    logic signed [DW-1:0] target;
    logic signed [DW-1:0] next;
    logic                 next_full;
    logic signed [DW:0]   step;
    logic signed [AW-1:0] acc;

    logic                 load_now;
    logic                 accept;
    logic signed [DW-1:0] a_new;
    logic signed [DW:0]   step_new;
    logic signed [AW-1:0] acc_load;
    logic signed [AW-1:0] acc_inc;

    always_comb begin
        load_now = next_full && (state != RUN || phase == R);
        s_ready  = !next_full || load_now;
        accept   = s_valid && s_ready;
        // A segment ending in RUN starts the next one from its own target
        a_new    = (state == RUN) ? target : base;
        step_new = {next[DW-1], next} - {a_new[DW-1], a_new};
        acc_load = {a_new, {RATIO_LOG2{1'b0}}} + {{(RATIO_LOG2-1){step_new[DW]}}, step_new};
        acc_inc  = acc + {{(RATIO_LOG2-1){step[DW]}}, step};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= '0;
            base      <= '0;
            target    <= '0;
            next      <= '0;
            next_full <= 1'b0;
            step      <= '0;
            acc       <= '0;
            dout      <= '0;
            valid_out <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (accept)
                next <= s_data;
            next_full <= accept || (next_full && !load_now);
            underrun  <= 1'b0;

            if (load_now) begin
                state     <= RUN;
                phase     <= PW'(1);
                base      <= a_new;
                target    <= next;
                step      <= step_new;
                acc       <= acc_load;
                dout      <= acc_load[AW-1:RATIO_LOG2];
                valid_out <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        valid_out <= 1'b0;
                        dout      <= '0;
                    end
                    RUN: begin
                        if (phase == R) begin
                            state    <= HOLD;
                            underrun <= 1'b1;
                            base     <= target;
                            dout     <= target;
                        end else begin
                            phase <= phase + 1'b1;
                            acc   <= acc_inc;
                            dout  <= acc_inc[AW-1:RATIO_LOG2];
                        end
                    end
                    HOLD: begin
                        valid_out <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/sdm_interpolator.md
Name: sdm_interpolator

Overview:
- Linear-interpolating upsampler that sits directly upstream of the sigma-delta modulator.
- Accepts signed PCM samples at the base rate (44.1 kHz) over a valid/ready handshake.
- Emits one interpolated sample per clk (2.8224 MHz, 64x) on valid_out/dout, which drive the modulator's valid_in/din.
- Ramps from 0 after reset to avoid a start-up click, and holds the last value on input underrun.

Parameters:
- DW, 16: PCM sample width, signed two's complement, in and out.
- RATIO_LOG2, 6: log2 of the interpolation ratio R (R = 64).

Ports:
- clk  in  1  modulator clock; one output sample per cycle.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  block can accept a sample this cycle.
- s_data  in  DW  signed PCM input sample.
- valid_out  out  1  dout is valid; connects to modulator valid_in.
- dout  out  DW  signed interpolated sample; connects to modulator din.
- underrun  out  1  one-cycle pulse when a segment ends with no next sample buffered.

Behaviour:
- Reset (async assert, sync release): state=IDLE, valid_out=0, dout=0, underrun=0, base=0, next_full=0. s_ready=1 while in reset and immediately after.
- Input buffer: one register `next` plus flag next_full.
  - Handshake completes at a rising edge when s_valid && s_ready; this sets next_full=1 and captures s_data.
  - s_ready = !next_full || load_now (combinational), where load_now = next_full && (state!=RUN || phase==R).
  - Simultaneous load and accept: `next` is overwritten and next_full stays 1.
- Segment: interpolates from base a to target b = `next` over R outputs.
  - step = b - a, DW+1 bits signed.
  - acc width DW+RATIO_LOG2; output k (k = 1..R) = (a*R + step*k) >>> RATIO_LOG2, i.e. floor division.
  - Output k=R equals b exactly; no saturation is needed.
- States:
  - IDLE: valid_out=0, dout=0, base=0. On load_now: compute step, output k=1 (valid_out=1), phase=1, go to RUN, clear next_full unless re-filled the same edge.
  - RUN: each edge phase++, acc+=step, dout=acc>>>RATIO_LOG2, valid_out=1.
    - At the edge after phase==R with next_full: base<=b, load the next segment and output its k=1 on that same edge. Back-to-back segments give exactly one output every clk with no gap.
    - At the edge after phase==R with !next_full: go to HOLD, pulse underrun=1 for that one cycle, base<=b.
  - HOLD: valid_out=1, dout=b held constant. On load_now, load as from IDLE, with base=b.
- Latency: sample accepted at edge N; when not in RUN, its k=1 output appears on dout at edge N+1.
- Steady state: 1 input per R clocks. The upstream source may fill `next` at any time during the current segment.
- Reset mid-segment: all of the above is cleared immediately. The next sample ramps again from 0.

Test Plan:
- From IDLE, one sample -16384 (0xC000) -> dout = -256, -512, ... -16384 on consecutive clks, valid_out=1 throughout. Then HOLD at -16384 with underrun pulsing exactly once, one clk after the 64th output.
- Continuous stream -16384 then +16384 with `next` always full -> second segment k=1 = -15872, k=64 = 16384. valid_out never drops, and no underrun.
- Full-scale -32768 then 32767 (step = 65535) -> k=1 = -31745, k=64 = 32767 exactly, and no wrap anywhere in the segment.
- Backpressure: hold s_valid=1 with a new value every cycle -> s_ready=0 except on load edges. Exactly one sample is accepted per 64 clks, and none is lost or duplicated.
- HOLD recovery: in HOLD at 1000, present 2000 -> next outputs 1015, 1031, ... 2000. Step 1000/64 is floored per k, so k=1 gives 1015 and k=2 gives 1031.
- Assert rst during phase 30 of a segment -> valid_out=0, dout=0 and s_ready=1 asynchronously. The next sample 640 ramps as 10, 20, ... 640.
